prog_sequencer: RTL and testbench

- Parametrised program-sequencing unit that generates the program-ROM address for the `computer` core.
- Replaces the fixed increment-only program counter with:
  - jump, call and return, backed by a hardware return stack of configurable depth;
  - halt and resume control;
  - stall;
  - a saturating retired-cycle counter, which lets benches bound a run without a hand-computed timeout.
- Sits between the instruction decoder (which supplies decoded control strobes and the target address) and the program ROM address input.

---
 rtl/prog_sequencer_pkg.sv | 15 +
 rtl/prog_sequencer_ret_stack.sv | 48 ++++
 rtl/prog_sequencer.sv | 123 ++++++++++++
 tb/tb_prog_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/prog_sequencer_pkg.sv
// rtl/prog_sequencer_pkg.sv - shared state encodings and default parameters for prog_sequencer
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    STATE_RUN   = 2'd0,
    STATE_HALT  = 2'd1,
    STATE_FAULT = 2'd2
  } seq_state_t;

  localparam int DEF_PROG_ADDR_SIZE = 8;
  localparam int DEF_STACK_DEPTH    = 4;
  localparam int DEF_CYCLE_CNT_SIZE = 16;
  localparam int DEF_RESET_VECTOR   = 0;

endpackage

// File: rtl/prog_sequencer_ret_stack.sv
// rtl/prog_sequencer_ret_stack.sv - parametrised LIFO return stack addressed by its fill level
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  // Index width is kept at least 1 so a single-entry stack still has a legal address
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entry [2**IDX_W];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx   = IDX_W'(level);
  assign rd_idx   = IDX_W'(level - LVL_W'(1));
  assign pop_data = entry[rd_idx];
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end else if (pop && !empty) begin
      level <= level - LVL_W'(1);
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entry[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program counter sequencer with jump/call/return, halt/resume, stall and cycle counter
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PROG_ADDR_SIZE = DEF_PROG_ADDR_SIZE,
  parameter int STACK_DEPTH    = DEF_STACK_DEPTH,
  parameter int CYCLE_CNT_SIZE = DEF_CYCLE_CNT_SIZE,
  parameter int RESET_VECTOR   = DEF_RESET_VECTOR,
  parameter int LVL_W          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      jump,
  input  logic                      call,
  input  logic                      ret,
  input  logic                      haltReq,
  input  logic                      resume,
  input  logic [PROG_ADDR_SIZE-1:0] target,
  output logic [PROG_ADDR_SIZE-1:0] progCounter,
  output logic                      halted,
  output logic                      fault,
  output logic                      stackOverflow,
  output logic                      stackUnderflow,
  output logic [LVL_W-1:0]          stackLevel,
  output logic [CYCLE_CNT_SIZE-1:0] cycleCount
);

  seq_state_t                state, state_nx;
  logic [PROG_ADDR_SIZE-1:0] pc_nx, pc_inc, stack_top;
  logic                      ovf_nx, unf_nx;
  logic [CYCLE_CNT_SIZE-1:0] cnt_nx;
  logic                      push, pop, stack_full, stack_empty;

  assign pc_inc = progCounter + PROG_ADDR_SIZE'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PROG_ADDR_SIZE),
    .LVL_W (LVL_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .level     (stackLevel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= STATE_RUN;
      progCounter    <= PROG_ADDR_SIZE'(RESET_VECTOR);
      stackOverflow  <= 1'b0;
      stackUnderflow <= 1'b0;
      cycleCount     <= '0;
    end else begin
      state          <= state_nx;
      progCounter    <= pc_nx;
      stackOverflow  <= ovf_nx;
      stackUnderflow <= unf_nx;
      cycleCount     <= cnt_nx;
    end
  end

  // Strobe priority in RUN: haltReq > ret > call > jump > increment
  always_comb begin
    state_nx = state;
    pc_nx    = progCounter;
    ovf_nx   = stackOverflow;
    unf_nx   = stackUnderflow;
    cnt_nx   = cycleCount;
    push     = 1'b0;
    pop      = 1'b0;
    case (state)
      STATE_RUN: begin
        if (!stall) begin
          if (cycleCount != '1) begin
            cnt_nx = cycleCount + CYCLE_CNT_SIZE'(1);
          end
          if (haltReq) begin
            state_nx = STATE_HALT;
          end else if (ret) begin
            if (!stack_empty) begin
              pop   = 1'b1;
              pc_nx = stack_top;
            end else begin
              unf_nx   = 1'b1;
              state_nx = STATE_FAULT;
            end
          end else if (call) begin
            if (!stack_full) begin
              push  = 1'b1;
              pc_nx = target;
            end else begin
              ovf_nx   = 1'b1;
              state_nx = STATE_FAULT;
            end
          end else if (jump) begin
            pc_nx = target;
          end else begin
            pc_nx = pc_inc;
          end
        end
      end
      STATE_HALT: begin
        if (resume) begin
          pc_nx    = pc_inc;
          state_nx = STATE_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  assign halted = (state != STATE_RUN);
  assign fault  = (state == STATE_FAULT);

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed self-checking bench for prog_sequencer
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset, stall, jump, call, ret, haltReq, resume;
  logic [7:0] target;
  logic [7:0] progCounter;
  logic       halted, fault, stackOverflow, stackUnderflow;
  logic [2:0] stackLevel;
  logic [15:0] cycleCount;

  int n_pass  = 0;
  int n_total = 0;

  prog_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .jump           (jump),
    .call           (call),
    .ret            (ret),
    .haltReq        (haltReq),
    .resume         (resume),
    .target         (target),
    .progCounter    (progCounter),
    .halted         (halted),
    .fault          (fault),
    .stackOverflow  (stackOverflow),
    .stackUnderflow (stackUnderflow),
    .stackLevel     (stackLevel),
    .cycleCount     (cycleCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; call = 0; ret = 0; haltReq = 0; resume = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    reset = 1;
  endtask

  initial begin
    idle();
    target = 8'h00;
    reset  = 0;
    #2;
    chk("rst_pc", progCounter, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", stackOverflow, 0);
    chk("rst_unf", stackUnderflow, 0);
    chk("rst_level", stackLevel, 0);
    chk("rst_cnt", cycleCount, 0);
    step();
    reset = 1;

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("inc_pc%0d", i), progCounter, i);
      step();
    end
    chk("inc_cnt", cycleCount, 5);
    chk("inc_halted", halted, 0);

    jump = 1; target = 8'h03; step();
    chk("jmp_pc3", progCounter, 8'h03);
    target = 8'h07; step();
    chk("jmp_pc7", progCounter, 8'h07);
    jump = 0; step();
    chk("jmp_pc8", progCounter, 8'h08);
    jump = 1; target = 8'hFF; step();
    chk("jmp_pcff", progCounter, 8'hFF);
    jump = 0; step();
    chk("wrap_pc", progCounter, 8'h00);

    jump = 1; target = 8'h05; step();
    jump = 0; call = 1; target = 8'h20; step();
    chk("call1_pc", progCounter, 8'h20);
    chk("call1_lvl", stackLevel, 1);
    call = 0; step();
    chk("call_inc_pc", progCounter, 8'h21);
    call = 1; target = 8'h30; step();
    chk("call2_pc", progCounter, 8'h30);
    chk("call2_lvl", stackLevel, 2);
    call = 0; ret = 1; step();
    chk("ret1_pc", progCounter, 8'h22);
    chk("ret1_lvl", stackLevel, 1);
    step();
    chk("ret2_pc", progCounter, 8'h06);
    chk("ret2_lvl", stackLevel, 0);
    ret = 0;

    call = 1;
    for (int i = 0; i < 4; i++) begin
      target = 8'h40 + 8'(i);
      step();
      chk($sformatf("nest_pc%0d", i), progCounter, 8'h40 + i);
      chk($sformatf("nest_lvl%0d", i), stackLevel, i + 1);
    end
    target = 8'h50; step();
    chk("ovf_flag", stackOverflow, 1);
    chk("ovf_fault", fault, 1);
    chk("ovf_halted", halted, 1);
    chk("ovf_pc", progCounter, 8'h43);
    chk("ovf_lvl", stackLevel, 4);
    call = 0; ret = 1; jump = 1; resume = 1; target = 8'h99; step(); step();
    chk("flt_pc", progCounter, 8'h43);
    chk("flt_lvl", stackLevel, 4);
    chk("flt_fault", fault, 1);
    chk("flt_cnt", cycleCount, 21);
    idle();
    #2 reset = 0;
    #1;
    chk("async_pc", progCounter, 0);
    chk("async_fault", fault, 0);
    chk("async_ovf", stackOverflow, 0);
    chk("async_lvl", stackLevel, 0);
    chk("async_cnt", cycleCount, 0);
    step();
    reset = 1;

    ret = 1; step();
    chk("unf_flag", stackUnderflow, 1);
    chk("unf_fault", fault, 1);
    chk("unf_pc", progCounter, 0);
    ret = 0;
    do_reset();
    chk("unf_clr", stackUnderflow, 0);

    jump = 1; target = 8'h10; step();
    jump = 0; haltReq = 1; step();
    chk("halt_halted", halted, 1);
    chk("halt_fault", fault, 0);
    haltReq = 0; jump = 1; call = 1; target = 8'h77;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt_pc%0d", i), progCounter, 8'h10);
      step();
    end
    chk("halt_lvl", stackLevel, 0);
    jump = 0; call = 0; resume = 1; stall = 1; step();
    chk("resume_pc", progCounter, 8'h11);
    chk("resume_halted", halted, 0);
    idle();

    haltReq = 1; call = 1; jump = 1; target = 8'h60; step();
    chk("pri_halted", halted, 1);
    chk("pri_lvl", stackLevel, 0);
    chk("pri_pc", progCounter, 8'h11);
    idle(); resume = 1; step();
    chk("pri_resume_pc", progCounter, 8'h12);
    idle(); stall = 1; jump = 1; target = 8'h55; step();
    chk("stall_pc", progCounter, 8'h12);
    chk("stall_cnt", cycleCount, 3);
    stall = 0; jump = 0; step();
    chk("post_stall_pc", progCounter, 8'h13);

    call = 1; target = 8'h70; step();
    chk("midcall_lvl", stackLevel, 1);
    #2 reset = 0;
    #1;
    chk("midcall_rst_lvl", stackLevel, 0);
    chk("midcall_rst_pc", progCounter, 0);
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
